// File: rtl/uart_frame_sequencer.sv
// Frame sequencer: parses decimal ASCII lines from a UART into an input RAM, kicks an
// accelerator, then prints each result word back as signed decimal text.
module uart_frame_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 512,
  parameter int NUM_OUT = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             in_we,
  output logic [8:0]       in_addr,
  output logic [WIDTH-1:0] in_wdata,
  output logic             acc_start,
  input  logic             acc_done,
  output logic [4:0]       out_addr,
  input  logic [WIDTH-1:0] out_rdata,
  output logic             busy,
  output logic             err_range,
  output logic             err_format,
  output logic             err_drop
);

  localparam logic [7:0]  CHR_MINUS = 8'h2D;
  localparam logic [7:0]  CHR_CR    = 8'h0D;
  localparam logic [7:0]  CHR_LF    = 8'h0A;
  localparam logic [7:0]  CHR_ZERO  = 8'h30;
  localparam logic [16:0] MAG_LIMIT = 17'd32768;
  localparam logic [8:0]  LAST_IN   = 9'(NUM_IN - 1);
  localparam logic [4:0]  LAST_OUT  = 5'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    ST_RX, ST_START, ST_WAIT, ST_RD, ST_CONV, ST_SEND
  } state_e;

  typedef enum logic [1:0] {
    K_SIGN, K_DIGIT, K_CR, K_LF
  } kind_e;

  // Decimal place weight for the repeated-subtraction digit extractor.
  function automatic logic [16:0] place_val(input logic [2:0] idx);
    logic [16:0] v;
    case (idx)
      3'd0:    v = 17'd10000;
      3'd1:    v = 17'd1000;
      3'd2:    v = 17'd100;
      3'd3:    v = 17'd10;
      default: v = 17'd1;
    endcase
    return v;
  endfunction

  state_e            state_r;
  kind_e             tx_kind_r;
  logic [8:0]        word_cnt_r;
  logic [4:0]        k_r;
  logic [16:0]       mag_r;
  logic              neg_r;
  logic              have_digit_r;
  logic              sat_r;
  logic              skip_r;
  logic              rd_phase_r;
  logic [2:0]        place_r;
  logic [3:0]        digit_r;
  logic              started_r;

  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              in_we_r;
  logic [8:0]        in_addr_r;
  logic [WIDTH-1:0]  in_wdata_r;
  logic              acc_start_r;
  logic [4:0]        out_addr_r;
  logic              err_range_r;
  logic              err_format_r;
  logic              err_drop_r;

  logic              is_digit_s;
  logic [20:0]       mac_s;
  logic [16:0]       mag_next_s;
  logic              sat_next_s;
  logic [15:0]       word_s;
  logic              range_hit_s;
  logic [WIDTH:0]    ext_s;
  logic [WIDTH:0]    abs_s;
  logic [16:0]       place_val_s;

  // Parser arithmetic, clamped line value and result-word magnitude.
  always_comb begin
    is_digit_s = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    mac_s      = ({4'd0, mag_r} * 21'd10) + {17'd0, rx_data[3:0]};
    mag_next_s = mac_s[16:0];
    sat_next_s = 1'b0;
    if (mac_s > {4'd0, MAG_LIMIT}) begin
      mag_next_s = MAG_LIMIT;
      sat_next_s = 1'b1;
    end else begin
      mag_next_s = mac_s[16:0];
      sat_next_s = 1'b0;
    end

    // A saturated magnitude still reads as 32768, so sat_r records that clamping happened.
    word_s      = mag_r[15:0];
    range_hit_s = 1'b0;
    if (neg_r) begin
      word_s      = 16'd0 - mag_r[15:0];
      range_hit_s = sat_r;
    end else if (mag_r >= MAG_LIMIT) begin
      word_s      = 16'h7FFF;
      range_hit_s = 1'b1;
    end else begin
      word_s      = mag_r[15:0];
      range_hit_s = 1'b0;
    end

    ext_s = {out_rdata[WIDTH-1], out_rdata};
    abs_s = ext_s;
    if (out_rdata[WIDTH-1]) begin
      abs_s = {(WIDTH+1){1'b0}} - ext_s;
    end else begin
      abs_s = ext_s;
    end

    place_val_s = place_val(place_r);
  end

  // Main sequencer: RX parse, accelerator handshake, readback and decimal transmit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r      <= ST_RX;
      tx_kind_r    <= K_SIGN;
      word_cnt_r   <= 9'd0;
      k_r          <= 5'd0;
      mag_r        <= 17'd0;
      neg_r        <= 1'b0;
      have_digit_r <= 1'b0;
      sat_r        <= 1'b0;
      skip_r       <= 1'b0;
      rd_phase_r   <= 1'b0;
      place_r      <= 3'd0;
      digit_r      <= 4'd0;
      started_r    <= 1'b0;
      tx_data_r    <= 8'd0;
      tx_valid_r   <= 1'b0;
      in_we_r      <= 1'b0;
      in_addr_r    <= 9'd0;
      in_wdata_r   <= {WIDTH{1'b0}};
      acc_start_r  <= 1'b0;
      out_addr_r   <= 5'd0;
      err_range_r  <= 1'b0;
      err_format_r <= 1'b0;
      err_drop_r   <= 1'b0;
    end else begin
      in_we_r     <= 1'b0;
      acc_start_r <= 1'b0;
      if (rx_valid && (state_r != ST_RX)) begin
        err_drop_r <= 1'b1;
      end

      case (state_r)
        ST_RX: begin
          if (rx_valid) begin
            if (skip_r) begin
              if (rx_data == CHR_CR) begin
                skip_r       <= 1'b0;
                neg_r        <= 1'b0;
                mag_r        <= 17'd0;
                have_digit_r <= 1'b0;
                sat_r        <= 1'b0;
              end
            end else if (rx_data == CHR_LF) begin
              skip_r <= 1'b0;
            end else if ((rx_data == CHR_MINUS) && !neg_r && !have_digit_r) begin
              neg_r <= 1'b1;
            end else if (is_digit_s) begin
              mag_r        <= mag_next_s;
              sat_r        <= sat_r | sat_next_s;
              have_digit_r <= 1'b1;
            end else if (rx_data == CHR_CR) begin
              if (have_digit_r) begin
                in_we_r    <= 1'b1;
                in_addr_r  <= word_cnt_r;
                in_wdata_r <= WIDTH'($signed(word_s));
                word_cnt_r <= word_cnt_r + 9'd1;
                if (range_hit_s) begin
                  err_range_r <= 1'b1;
                end
                if (word_cnt_r == LAST_IN) begin
                  state_r <= ST_START;
                end
              end
              neg_r        <= 1'b0;
              mag_r        <= 17'd0;
              have_digit_r <= 1'b0;
              sat_r        <= 1'b0;
            end else begin
              err_format_r <= 1'b1;
              skip_r       <= 1'b1;
              neg_r        <= 1'b0;
              mag_r        <= 17'd0;
              have_digit_r <= 1'b0;
              sat_r        <= 1'b0;
            end
          end
        end

        ST_START: begin
          acc_start_r <= 1'b1;
          state_r     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (acc_done) begin
            out_addr_r <= k_r;
            rd_phase_r <= 1'b0;
            state_r    <= ST_RD;
          end
        end

        // Phase 0 lets the RAM register out_addr; phase 1 captures its data.
        ST_RD: begin
          if (!rd_phase_r) begin
            rd_phase_r <= 1'b1;
          end else begin
            rd_phase_r <= 1'b0;
            neg_r      <= out_rdata[WIDTH-1];
            mag_r      <= 17'(abs_s);
            place_r    <= 3'd0;
            digit_r    <= 4'd0;
            started_r  <= 1'b0;
            if (out_rdata[WIDTH-1]) begin
              tx_data_r  <= CHR_MINUS;
              tx_valid_r <= 1'b1;
              tx_kind_r  <= K_SIGN;
              state_r    <= ST_SEND;
            end else begin
              state_r <= ST_CONV;
            end
          end
        end

        ST_CONV: begin
          if (mag_r >= place_val_s) begin
            mag_r   <= mag_r - place_val_s;
            digit_r <= digit_r + 4'd1;
          end else if ((digit_r != 4'd0) || started_r || (place_r == 3'd4)) begin
            tx_data_r  <= CHR_ZERO + {4'd0, digit_r};
            tx_valid_r <= 1'b1;
            tx_kind_r  <= K_DIGIT;
            started_r  <= 1'b1;
            place_r    <= place_r + 3'd1;
            digit_r    <= 4'd0;
            state_r    <= ST_SEND;
          end else begin
            place_r <= place_r + 3'd1;
            digit_r <= 4'd0;
          end
        end

        ST_SEND: begin
          if (tx_valid_r && tx_ready) begin
            case (tx_kind_r)
              K_SIGN, K_DIGIT: begin
                if (place_r == 3'd5) begin
                  tx_data_r <= CHR_CR;
                  tx_kind_r <= K_CR;
                end else begin
                  tx_valid_r <= 1'b0;
                  state_r    <= ST_CONV;
                end
              end
              K_CR: begin
                tx_data_r <= CHR_LF;
                tx_kind_r <= K_LF;
              end
              K_LF: begin
                tx_valid_r <= 1'b0;
                if (k_r == LAST_OUT) begin
                  k_r        <= 5'd0;
                  out_addr_r <= 5'd0;
                  word_cnt_r <= 9'd0;
                  neg_r      <= 1'b0;
                  mag_r      <= 17'd0;
                  state_r    <= ST_RX;
                end else begin
                  k_r        <= k_r + 5'd1;
                  out_addr_r <= k_r + 5'd1;
                  rd_phase_r <= 1'b0;
                  state_r    <= ST_RD;
                end
              end
              default: begin
                tx_valid_r <= 1'b0;
                state_r    <= ST_RX;
              end
            endcase
          end
        end

        default: begin
          state_r <= ST_RX;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign in_we      = in_we_r;
  assign in_addr    = in_addr_r;
  assign in_wdata   = in_wdata_r;
  assign acc_start  = acc_start_r;
  assign out_addr   = out_addr_r;
  assign err_range  = err_range_r;
  assign err_format = err_format_r;
  assign err_drop   = err_drop_r;
  // Idle only with nothing collected: decoded purely from flops, so it changes on clock edges.
  assign busy = !((state_r == ST_RX) && (word_cnt_r == 9'd0) &&
                  !neg_r && !have_digit_r && !skip_r);

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample word width.
REQ-002 SHALL have parameter NUM_IN, default 512, input words per frame.
REQ-003 SHALL have parameter NUM_OUT, default 32, result words per frame.
REQ-004 SHALL have port sysclk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_data  in  8  received UART byte.
REQ-007 SHALL have port rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port tx_data  out  8  byte to UART transmitter.
REQ-009 SHALL have port tx_valid  out  1  tx_data valid.
REQ-010 SHALL have port tx_ready  in  1  transmitter accepts byte.
REQ-011 SHALL have ports in_we, in_addr, in_wdata  out  1/9/WIDTH  input-RAM write port.
REQ-012 SHALL have ports acc_start out 1 and acc_done in 1: accelerator start pulse and done pulse.
REQ-013 SHALL have ports out_addr out 5 and out_rdata in WIDTH: result-RAM read port, 1-cycle read latency.
REQ-014 SHALL have outputs busy 1, err_range 1, err_format 1, err_drop 1; all error flags sticky until reset.

Function
REQ-015 SHALL implement states RX, START, WAIT, RD, CONV, SEND; RX is the reset state.
REQ-016 RX: on rx_valid, SHALL accept '-' (0x2D) only as the first character of a word and set the negative flag.
REQ-017 RX: on rx_valid with a digit 0x30-0x39, SHALL set mag = mag*10 + digit; mag is held saturated at 32768 with 17 bits or more.
REQ-018 RX: on rx_valid with CR (0x0D) and at least one digit received, SHALL pulse in_we for 1 cycle with in_addr = word count and in_wdata = the signed value, then increment word count.
REQ-019 The written value SHALL be clamped to [-32768, 32767], and err_range SHALL be set if clamping occurred.
REQ-020 CR with no digits SHALL produce no write; LF (0x0A) SHALL be ignored in all RX positions.
REQ-021 Any other byte, or a misplaced '-', SHALL set err_format, discard the current word, and skip bytes up to the next CR.
REQ-022 SHALL enter START on the cycle after the NUM_IN-th write, and pulse acc_start for exactly 1 cycle.
REQ-023 WAIT SHALL hold until acc_done is 1; an acc_done seen in any other state SHALL be ignored.
REQ-024 rx_valid in any state other than RX SHALL drop the byte and set err_drop.
REQ-025 RD: SHALL drive out_addr = k (k from 0 to NUM_OUT-1) and capture out_rdata on the following cycle, then go to CONV.
REQ-026 CONV/SEND: SHALL emit '-' if the value is negative, then the magnitude in decimal with no leading zeros ("0" for zero), then CR and LF.
REQ-027 CONV/SEND: digits SHALL be derived by repeated subtraction of 10000, 1000, 100, 10 and 1; no divider is used.
REQ-028 A byte SHALL transfer only on a cycle where tx_valid and tx_ready are both 1.
REQ-029 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable and tx_valid SHALL stay asserted.
REQ-030 After LF of word NUM_OUT-1, SHALL clear word count and k, and return to RX; the error flags SHALL persist.
REQ-031 busy SHALL be 0 only in RX with word count 0 and no partial word pending.

Reset
REQ-032 Reset SHALL return the block to RX on the next edge, from any state including mid-word and mid-SEND.
REQ-033 Reset SHALL set to 0: tx_valid, tx_data, in_we, in_addr, in_wdata, acc_start, out_addr, busy, all error flags, word count, k, mag and the negative flag.
REQ-034 Reset SHALL NOT alter RAM contents; a byte partially sent at reset is abandoned.

Verification
REQ-035 Bytes "-123\r" -> exactly one in_we pulse, in_addr=0, in_wdata=0xFF85, no error flags set.
REQ-036 "40000\r" then "-32768\r" -> writes 0x7FFF then 0x8000; err_range=1 after the first line only.
REQ-037 "1a2\r", then "\r", then "7\r" -> one write total (0x0007 at addr 0); err_format=1.
REQ-038 512 valid lines -> single 1-cycle acc_start on the cycle after the 512th write; rx byte sent during WAIT -> err_drop=1; acc_done pulsed 10 cycles later -> out_addr=0 issued.
REQ-039 out_rdata sequence 0xFF85, 0x0000, 0x8000 with tx_ready randomly low -> tx stream "-123\r\n0\r\n-32768\r\n", tx_data stable while stalled.
REQ-040 Reset asserted during WAIT and during SEND -> next cycle all outputs 0, state RX; the next line writes to in_addr=0.
